// File: rtl/alarm_buzzer_ctrl_pkg.sv
// Shared types and default timing for the alarm buzzer sequencer.
package alarm_buzzer_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2,
    StAck    = 2'd3
  } state_e;

  // Default timing at 100 MHz
  localparam int unsigned DefToneHalf    = 25000;     // 2 kHz tone
  localparam int unsigned DefCadenceHalf = 25000000;  // 250 ms on / off
  localparam int unsigned DefSecCyc      = 100000000; // 1 s tick
  localparam int unsigned DefRingSec     = 60;
  localparam int unsigned DefSnoozeSec   = 300;

  // Counter width for a counter that must hold values up to n-1 (never below 1 bit)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_buzzer_ctrl_if.sv
// Digit, control-pulse and status bundle between the clock core and the alarm sequencer.
interface alarm_buzzer_ctrl_if;
  logic       alarm_en;
  logic [3:0] hr_10s;
  logic [3:0] hr_1s;
  logic [3:0] min_10s;
  logic [3:0] min_1s;
  logic [3:0] alarm_hr_10s;
  logic [3:0] alarm_hr_1s;
  logic [3:0] alarm_min_10s;
  logic [3:0] alarm_min_1s;
  logic       snooze;
  logic       stop;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;

  modport master (
    output alarm_en, hr_10s, hr_1s, min_10s, min_1s,
    output alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
    output snooze, stop,
    input  buzzer, ringing, snoozing
  );

  modport slave (
    input  alarm_en, hr_10s, hr_1s, min_10s, min_1s,
    input  alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s,
    input  snooze, stop,
    output buzzer, ringing, snoozing
  );
endinterface

// File: rtl/alarm_buzzer_ctrl_tick_divider.sv
// Tick divider: counts enabled cycles and emits a one-cycle pulse every N of them.
// A synchronous clear restarts the count from zero and overrides the enable.
module alarm_buzzer_ctrl_tick_divider
  import alarm_buzzer_ctrl_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = cnt_width(N);
  localparam logic [W-1:0] Last = W'(N - 1);

  logic [W-1:0] cnt_q;

  assign tick = en & (cnt_q == Last);

  // Count enabled cycles, wrapping on the pulse
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/alarm_buzzer_ctrl.sv
// Alarm sequencer: detects the alarm minute, rings a gated tone with on/off cadence,
// and handles snooze, stop and auto-timeout without re-ringing inside an acknowledged minute.
module alarm_buzzer_ctrl
  import alarm_buzzer_ctrl_pkg::*;
#(
  parameter int unsigned TONE_HALF    = DefToneHalf,
  parameter int unsigned CADENCE_HALF = DefCadenceHalf,
  parameter int unsigned SEC_CYC      = DefSecCyc,
  parameter int unsigned RING_SEC     = DefRingSec,
  parameter int unsigned SNOOZE_SEC   = DefSnoozeSec
) (
  input logic                 clk_100MHz,
  input logic                 reset,
  alarm_buzzer_ctrl_if.slave  bus
);

  localparam int unsigned SecMax = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int unsigned SecW   = cnt_width(SecMax);
  localparam logic [SecW-1:0] SecTop      = SecW'(SecMax - 1);
  localparam logic [SecW-1:0] RingLast    = SecW'(RING_SEC - 1);
  localparam logic [SecW-1:0] SnoozeLast  = SecW'(SNOOZE_SEC - 1);

  state_e state_q, state_d;

  logic            match_r;
  logic            arm_d;
  logic            arm;
  logic            trigger;
  logic            ring_entry;
  logic            snooze_entry;
  logic            in_ring;
  logic            in_snooze;
  logic            tone_tick;
  logic            cad_tick;
  logic            sec_tick;
  logic            ring_timeout;
  logic            snooze_expire;
  logic            tone_q;
  logic            cad_q;
  logic            buzzer_q;
  logic [SecW-1:0] sec_cnt_q;

  assign arm     = bus.alarm_en & match_r;
  assign trigger = arm & ~arm_d;

  // Register the HH:MM equality and the previous arm level for edge detection
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      match_r <= 1'b0;
      arm_d   <= 1'b0;
    end else begin
      match_r <= ({bus.hr_10s, bus.hr_1s, bus.min_10s, bus.min_1s} ==
                  {bus.alarm_hr_10s, bus.alarm_hr_1s, bus.alarm_min_10s, bus.alarm_min_1s});
      arm_d   <= arm;
    end
  end

  assign in_ring       = (state_q == StRing);
  assign in_snooze     = (state_q == StSnooze);
  assign ring_entry    = (state_d == StRing) & ~in_ring;
  assign snooze_entry  = (state_d == StSnooze) & ~in_snooze;
  assign ring_timeout  = sec_tick & (sec_cnt_q == RingLast);
  assign snooze_expire = sec_tick & (sec_cnt_q == SnoozeLast);

  // State register
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; disable beats stop, stop beats snooze, snooze beats timeout
  always_comb begin
    state_d = state_q;
    if (!bus.alarm_en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (trigger) state_d = StRing;
        end
        StRing: begin
          if (bus.stop)        state_d = StAck;
          else if (bus.snooze) state_d = StSnooze;
          else if (ring_timeout) state_d = StAck;
        end
        StSnooze: begin
          if (bus.stop)           state_d = StAck;
          else if (snooze_expire) state_d = StRing;
        end
        StAck: begin
          // Hold off until the matching minute has passed
          if (!match_r) state_d = StIdle;
        end
      endcase
    end
  end

  alarm_buzzer_ctrl_tick_divider #(.N(TONE_HALF)) u_tone_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clr        (ring_entry),
    .en         (in_ring),
    .tick       (tone_tick)
  );

  alarm_buzzer_ctrl_tick_divider #(.N(CADENCE_HALF)) u_cad_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clr        (ring_entry),
    .en         (in_ring),
    .tick       (cad_tick)
  );

  alarm_buzzer_ctrl_tick_divider #(.N(SEC_CYC)) u_sec_div (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .clr        (ring_entry | snooze_entry),
    .en         (in_ring | in_snooze),
    .tick       (sec_tick)
  );

  // Seconds elapsed in the current RING or SNOOZE visit, saturating
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sec_cnt_q <= '0;
    end else if (ring_entry | snooze_entry) begin
      sec_cnt_q <= '0;
    end else if (sec_tick && (sec_cnt_q != SecTop)) begin
      sec_cnt_q <= sec_cnt_q + SecW'(1);
    end
  end

  // Tone square wave and cadence gate, restarted on every RING entry
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tone_q <= 1'b0;
      cad_q  <= 1'b0;
    end else if (ring_entry) begin
      tone_q <= 1'b0;
      cad_q  <= 1'b1;
    end else begin
      if (tone_tick) tone_q <= ~tone_q;
      if (cad_tick)  cad_q  <= ~cad_q;
    end
  end

  // Registered buzzer; dropping out of RING silences it on the same edge
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      buzzer_q <= 1'b0;
    end else begin
      buzzer_q <= in_ring & (state_d == StRing) & tone_q & cad_q;
    end
  end

  assign bus.buzzer   = buzzer_q;
  assign bus.ringing  = in_ring;
  assign bus.snoozing = in_snooze;

endmodule

// File: tb/tb_alarm_buzzer_ctrl.sv
// Cycle-by-cycle bench for alarm_buzzer_ctrl with small timing parameters.
module tb_alarm_buzzer_ctrl;

  localparam logic [15:0] T0729 = 16'h0729;
  localparam logic [15:0] T0730 = 16'h0730;
  localparam logic [15:0] T0731 = 16'h0731;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [15:0] tm;
    logic        snz;
    logic        stp;
    logic        buz;
    logic        rng;
    logic        sng;
  } vec_t;

  logic clk_100MHz = 1'b0;
  logic reset;

  alarm_buzzer_ctrl_if bus ();

  alarm_buzzer_ctrl #(
    .TONE_HALF    (2),
    .CADENCE_HALF (8),
    .SEC_CYC      (10),
    .RING_SEC     (3),
    .SNOOZE_SEC   (2)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [2:0]  exp_q[$];
  vec_t        tbl[35];

  function automatic vec_t mk(input logic rst, input logic en, input logic [15:0] tm,
                              input logic snz, input logic stp,
                              input logic buz, input logic rng, input logic sng);
    vec_t v;
    v.rst = rst; v.en = en; v.tm = tm; v.snz = snz; v.stp = stp;
    v.buz = buz; v.rng = rng; v.sng = sng;
    return v;
  endfunction

  // Buzzer level k cycles after RING entry: 0,0,1,1,0,0,1,1 then eight zeros, repeating
  function automatic logic pat(input int k);
    int m;
    if (k < 1) return 1'b0;
    m = (k - 1) % 16;
    return (m < 8) && ((m % 4) >= 2);
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge
  task automatic apply(input vec_t v, input string tag);
    logic [2:0] got;
    logic [2:0] want;
    reset = v.rst;
    bus.alarm_en = v.en;
    {bus.hr_10s, bus.hr_1s, bus.min_10s, bus.min_1s} = v.tm;
    bus.snooze = v.snz;
    bus.stop   = v.stp;
    exp_q.push_back({v.buz, v.rng, v.sng});
    @(posedge clk_100MHz);
    #1;
    got  = {bus.buzzer, bus.ringing, bus.snoozing};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s vec %0d: buzzer/ringing/snoozing got %b want %b", tag, n_vec, got, want);
    end
  endtask

  task automatic ring_seq(input int k0, input int k1, input string tag);
    for (int k = k0; k <= k1; k++) apply(mk(1'b0, 1'b1, T0730, 1'b0, 1'b0, pat(k), 1'b1, 1'b0), tag);
  endtask

  task automatic idle_n(input int n, input logic [15:0] tm, input string tag);
    for (int i = 0; i < n; i++) apply(mk(1'b0, 1'b1, tm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), tag);
  endtask

  initial begin
    bus.alarm_hr_10s  = 4'd0;
    bus.alarm_hr_1s   = 4'd7;
    bus.alarm_min_10s = 4'd3;
    bus.alarm_min_1s  = 4'd0;

    // Reset, 07:29 -> 07:30, full ring to auto-timeout
    tbl[0] = mk(1'b1, 1'b1, T0729, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 1'b1, T0729, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, 1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++)
      tbl[3 + k] = mk(1'b0, 1'b1, T0730, 1'b0, 1'b0, pat(k), 1'b1, 1'b0);
    tbl[33] = mk(1'b0, 1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[34] = mk(1'b0, 1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 35; i++) apply(tbl[i], (i == 0) ? "reset" : "ring_timeout");

    // ACK holds through the matching minute, then releases and re-arms
    idle_n(4, T0730, "ack_hold");
    idle_n(2, T0731, "ack_release");
    idle_n(1, T0730, "rearm_match");
    ring_seq(0, 4, "rering");

    // Snooze at cycle 5, re-ring after two seconds, then stop
    apply(mk(1'b0, 1'b1, T0730, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "snooze_enter");
    for (int i = 0; i < 19; i++)
      apply(mk(1'b0, 1'b1, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "snooze_hold");
    ring_seq(0, 4, "snooze_rering");
    apply(mk(1'b0, 1'b1, T0730, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "stop");
    idle_n(2, T0730, "stop_ack");

    // Enable toggled inside the matching minute rings; disable mid-ring idles
    apply(mk(1'b0, 1'b0, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "en_off");
    apply(mk(1'b0, 1'b0, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "en_off");
    ring_seq(0, 4, "en_on_ring");
    apply(mk(1'b0, 1'b0, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "en_off_midring");
    apply(mk(1'b0, 1'b0, T0730, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "en_off_idle");

    // Snooze and stop together: stop wins
    ring_seq(0, 1, "both_ring");
    apply(mk(1'b0, 1'b1, T0730, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "snooze_stop");
    idle_n(1, T0730, "snooze_stop_ack");

    // Stop on the timeout cycle
    idle_n(2, T0731, "release");
    idle_n(1, T0730, "rearm_match");
    ring_seq(0, 29, "stop_timeout_ring");
    apply(mk(1'b0, 1'b1, T0730, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), "stop_timeout");
    idle_n(1, T0730, "stop_timeout_ack");

    // Reset on the trigger cycle
    idle_n(2, T0731, "release");
    idle_n(1, T0730, "rearm_match");
    apply(mk(1'b1, 1'b1, T0731, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_trigger");
    idle_n(3, T0731, "post_reset_idle");

    // Reset mid-snooze, then no ring until arm rises again
    idle_n(1, T0730, "rearm_match");
    ring_seq(0, 1, "snz_ring");
    apply(mk(1'b0, 1'b1, T0730, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), "snz_enter");
    for (int i = 0; i < 3; i++)
      apply(mk(1'b0, 1'b1, T0731, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "snz_off_minute");
    apply(mk(1'b1, 1'b1, T0731, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_snooze");
    idle_n(10, T0731, "post_reset_quiet");
    apply(mk(1'b0, 1'b1, T0731, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "idle_pulses_ignored");
    idle_n(14, T0731, "post_reset_quiet");
    idle_n(1, T0730, "fresh_match");
    ring_seq(0, 0, "fresh_ring");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_buzzer_ctrl.md
Name: alarm_buzzer_ctrl

Overview:
Downstream consumer of the clock-core digit outputs and alarm digit registers. It replaces the free-toggling buzzer flop in the top level with a proper alarm sequencer. The sequencer compares the current HH:MM against the alarm HH:MM and rings a gated square-wave tone with an on/off cadence. It supports snooze, stop and an auto-timeout, and never re-rings within the same matching minute after acknowledgement. Its outputs drive the buzzer pin and status LEDs/overlay.

Parameters:
TONE_HALF, 25000, clk cycles per half period of the tone (2 kHz at 100 MHz)
CADENCE_HALF, 25000000, clk cycles per beep-on / beep-off phase (250 ms)
SEC_CYC, 100000000, clk cycles per second tick
RING_SEC, 60, seconds of ringing before auto-timeout
SNOOZE_SEC, 300, seconds of silence in snooze before re-ring

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-high reset
alarm_en  in  1  alarm enable switch level
hr_10s, hr_1s, min_10s, min_1s  in  4 each  current time BCD digits
alarm_hr_10s, alarm_hr_1s, alarm_min_10s, alarm_min_1s  in  4 each  alarm BCD digits
snooze  in  1  single-cycle pulse, already debounced
stop  in  1  single-cycle pulse, already debounced
buzzer  out  1  gated tone to piezo
ringing  out  1  high while in RING
snoozing  out  1  high while in SNOOZE

Behaviour:
- Clock and reset: one clock, clk_100MHz. Reset is synchronous and active-high. Reset forces state IDLE, clears all counters and match_r/arm_d, and drives buzzer=0, ringing=0, snoozing=0. A reset mid-ring silences the buzzer on the next edge.
- Match detection: match_r is a registered 16-bit equality of the four time digits against the four alarm digits.
- Trigger: arm = alarm_en & match_r, and arm_d is arm delayed one cycle. The trigger is arm & ~arm_d, a rising edge. Enabling the alarm inside the matching minute therefore rings.
- States: IDLE, RING, SNOOZE, ACK, held in a 2-bit state register.
- IDLE: on trigger, go to RING.
- RING:
  - stop goes to ACK.
  - snooze goes to SNOOZE.
  - After the RING_SEC-th second tick, go to ACK (timeout).
- SNOOZE: buzzer is silent. After the SNOOZE_SEC-th second tick, go to RING, whether or not match_r is set. stop goes to ACK.
- ACK: buzzer is silent. When match_r=0, go to IDLE. This blocks re-trigger within the same minute.
- Global override: alarm_en=0 in any state goes to IDLE on the next edge.
- Priority when events coincide: reset > alarm_en low > stop > snooze > timeout / snooze expiry.
- Snooze pulse outside RING is ignored. Stop pulse in IDLE or ACK is ignored.
- Counter restart on entry to RING:
  - tone counter=0, tone=0
  - cadence counter=0, cad_on=1
  - second prescaler=0, second counter=0
- Counter restart on entry to SNOOZE: second prescaler=0, second counter=0.
- Tone and cadence counters run only in RING:
  - tone toggles when its counter hits TONE_HALF-1, then the counter wraps to 0.
  - cad_on toggles when its counter hits CADENCE_HALF-1, same wrap.
- Second tick: the prescaler pulses when it hits SEC_CYC-1 and wraps. The second counter increments on each pulse and saturates at its terminal value.
- Counter widths are $clog2 of the terminal value (minimum 1).
- buzzer is registered: buzzer <= (state==RING) & tone & cad_on.
- ringing and snoozing are a direct decode of the state register, with no extra delay.
- Latency:
  - Digit change at edge N gives match_r at N+1 and state RING at N+2; ringing is high from N+2.
  - First buzzer high occurs TONE_HALF+1 cycles after RING entry.
- Leaving RING forces buzzer to 0 on the next edge.

Decomposition:
- alarm_defs.vh: state encodings (IDLE=0, RING=1, SNOOZE=2, ACK=3) and default timing constants.
- One sub-module, tick_divider (parameter N): enable counter with a sync clear, emitting a 1-cycle pulse every N cycles.
- tick_divider is instantiated three times: tone, cadence and second prescaler. All FSM logic stays in alarm_buzzer_ctrl.

Test Plan:
Bench parameters: TONE_HALF=2, CADENCE_HALF=8, SEC_CYC=10, RING_SEC=3, SNOOZE_SEC=2.
1. alarm_en=1, alarm 07:30, time steps 07:29→07:30 -> ringing rises 2 cycles later. buzzer pattern is 0,0,1,1,0,0,1,1 during cad_on and 0 for 8 cycles during cad_off. Auto-timeout to ACK after 30 cycles; ringing=0.
2. Ringing, snooze pulse at cycle 5 -> snoozing=1 and buzzer=0 next edge. Re-enters RING 20 cycles later with counters restarted. Stop pulse then -> ACK.
3. ACK with time held at 07:30 -> no re-ring. Time 07:31 -> IDLE. Time back to 07:30 -> rings again.
4. Alarm time matches, alarm_en toggled 0→1 -> rings. alarm_en→0 mid-RING -> IDLE, buzzer=0 next edge.
5. Same-cycle snooze+stop in RING -> ACK. Same-cycle stop+timeout -> ACK. Same-cycle reset+trigger -> IDLE, all outputs 0.
6. Reset asserted mid-SNOOZE for 1 cycle -> all outputs 0 and IDLE. No ring until a fresh rising edge of arm.
